// File: rtl/regfile.sv
// Eight 16-bit CPU registers (R0 = program counter, R1 = link, R7 = ALU temp) with one write port,
// a gated bus read port, two ungated ALU operand ports and a PC increment; synchronous active-high reset.
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  input  logic [2:0]  reg_src_sel,
  input  logic [2:0]  reg_dst_sel,
  input  logic        reg_in_en,
  input  logic        reg_out_en,
  input  logic        reg_pc_inc,
  output logic [15:0] out,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [15:0] pc
);

  logic [7:0][15:0] regs_q;
  logic [7:0][15:0] regs_d;

  // The bus write is applied after the increment so that a write to R0 overrides it.
  always_comb begin
    regs_d = regs_q;
    if (reg_pc_inc) begin
      regs_d[0] = regs_q[0] + 16'd1;
    end
    if (reg_in_en) begin
      regs_d[reg_dst_sel] = in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // All read ports come from the flops only, so there is no path from in to out.
  assign out   = reg_out_en ? regs_q[reg_src_sel] : 16'h0000;
  assign alu_a = regs_q[reg_dst_sel];
  assign alu_b = regs_q[reg_src_sel];
  assign pc    = regs_q[0];

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

  logic        clk;
  logic        rst;
  logic [15:0] in;
  logic [2:0]  reg_src_sel;
  logic [2:0]  reg_dst_sel;
  logic        reg_in_en;
  logic        reg_out_en;
  logic        reg_pc_inc;
  logic [15:0] out;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] pc;

  int checks;
  int failures;

  regfile dut (
    .clk         (clk),
    .rst         (rst),
    .in          (in),
    .reg_src_sel (reg_src_sel),
    .reg_dst_sel (reg_dst_sel),
    .reg_in_en   (reg_in_en),
    .reg_out_en  (reg_out_en),
    .reg_pc_inc  (reg_pc_inc),
    .out         (out),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .pc          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] din;
    logic [2:0]  src;
    logic [2:0]  dst;
    logic        in_en;
    logic        out_en;
    logic        pc_inc;
    logic [15:0] e_out;
    logic [15:0] e_a;
    logic [15:0] e_b;
    logic [15:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [15:0] d, input logic [2:0] s,
                              input logic [2:0] t, input logic ie, input logic oe, input logic pi,
                              input logic [15:0] eo, input logic [15:0] ea, input logic [15:0] eb,
                              input logic [15:0] ep);
    vec_t v;
    v.rst = r; v.din = d; v.src = s; v.dst = t; v.in_en = ie; v.out_en = oe; v.pc_inc = pi;
    v.e_out = eo; v.e_a = ea; v.e_b = eb; v.e_pc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [15:0] d, input logic [2:0] s, input logic [2:0] t,
                       input logic ie, input logic oe, input logic pi);
    rst = r; in = d; reg_src_sel = s; reg_dst_sel = t;
    reg_in_en = ie; reg_out_en = oe; reg_pc_inc = pi;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;

    // Expected outputs are the values visible before the vector's rising edge.
    //                rst din       src   dst   ie    oe    pi    out       alu_a     alu_b     pc
    vecs.push_back(mk(0, 16'h1234, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 16'h1111, 3'd3, 3'd4, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h0000, 16'h1234, 16'h0000));
    vecs.push_back(mk(1, 16'hBEEF, 3'd4, 3'd4, 1'b1, 1'b1, 1'b1, 16'h1111, 16'h1111, 16'h1111, 16'h0001));
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(0, 16'h0000, 3'(i), 3'(i), 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    end
    vecs.push_back(mk(0, 16'hABCD, 3'd5, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 3'd5, 3'd5, 1'b0, 1'b1, 1'b0, 16'hABCD, 16'hABCD, 16'hABCD, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hABCD, 16'h0000));
    vecs.push_back(mk(0, 16'hFFFE, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 3'd0, 3'd5, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hABCD, 16'hFFFE, 16'hFFFE));
    vecs.push_back(mk(0, 16'h0000, 3'd0, 3'd5, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hABCD, 16'hFFFF, 16'hFFFF));
    vecs.push_back(mk(0, 16'h0000, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hABCD, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 16'h0010, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 16'h0200, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0010, 16'h0010, 16'h0010));
    vecs.push_back(mk(0, 16'h0010, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0200, 16'h0000, 16'h0200));
    vecs.push_back(mk(0, 16'h0055, 3'd1, 3'd1, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0010));
    vecs.push_back(mk(0, 16'h0000, 3'd1, 3'd0, 1'b0, 1'b1, 1'b0, 16'h0055, 16'h0011, 16'h0055, 16'h0011));
    vecs.push_back(mk(0, 16'h0007, 3'd7, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0011));
    vecs.push_back(mk(0, 16'h0003, 3'd2, 3'd7, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0007, 16'h0011));
    vecs.push_back(mk(0, 16'h0009, 3'd7, 3'd2, 1'b1, 1'b1, 1'b0, 16'h0003, 16'h0007, 16'h0003, 16'h0011));
    vecs.push_back(mk(0, 16'h0000, 3'd7, 3'd2, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0009, 16'h0003, 16'h0011));
    vecs.push_back(mk(0, 16'h5A5A, 3'd6, 3'd6, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0011));
    vecs.push_back(mk(0, 16'h0000, 3'd6, 3'd6, 1'b0, 1'b1, 1'b0, 16'h5A5A, 16'h5A5A, 16'h5A5A, 16'h0011));
    vecs.push_back(mk(0, 16'h0000, 3'd5, 3'd2, 1'b0, 1'b1, 1'b0, 16'hABCD, 16'h0009, 16'hABCD, 16'h0011));

    // Power-on reset with the bus undriven.
    drive(1'b1, 16'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 chk("reset_out_gated", out, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("reset_pc", pc, 16'h0000);
    chk("reset_out", out, 16'h0000);

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].rst, vecs[k].din, vecs[k].src, vecs[k].dst,
            vecs[k].in_en, vecs[k].out_en, vecs[k].pc_inc);
      #2;
      chk($sformatf("v%0d_out", k), out, vecs[k].e_out);
      chk($sformatf("v%0d_alu_a", k), alu_a, vecs[k].e_a);
      chk($sformatf("v%0d_alu_b", k), alu_b, vecs[k].e_b);
      chk($sformatf("v%0d_pc", k), pc, vecs[k].e_pc);
      @(posedge clk);
    end

    // Read-during-write on the write edge itself: alu_a flips only after the edge.
    @(negedge clk);
    drive(1'b0, 16'h0042, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);
    #2 chk("rdw_before", alu_a, 16'h0000);
    @(posedge clk);
    #1 chk("rdw_after", alu_a, 16'h0042);

    // Mid-run reset while idle clears a written register; out stays 0 while ungated off.
    @(negedge clk);
    drive(1'b1, 16'h0000, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0);
    #2 chk("rst2_out_off", out, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 16'h0000, 3'd3, 3'd2, 1'b0, 1'b1, 1'b0);
    #2;
    chk("rst2_r3", out, 16'h0000);
    chk("rst2_r2", alu_a, 16'h0000);
    chk("rst2_pc", pc, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
